// File: rtl/downsampler2_pkg.sv
// Shared sampling constants and helpers used by both the downsampler and the upsampler.
package downsampler2_pkg;

  localparam int DEF_NUMCOL = 800;
  localparam int DEF_NUMROW = 600;
  localparam int CNT_W      = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter step that wraps to zero after reaching the given terminal value.
  function automatic cnt_t wrap_inc(input cnt_t value, input int unsigned last);
    return (value == cnt_t'(last)) ? '0 : value + cnt_t'(1);
  endfunction

endpackage

// File: rtl/downsampler2_line_buffer.sv
// Simple dual-port RAM holding one row of horizontal pair sums; synchronous read
// with read-enable, so read data stays put between reads.
module line_buffer #(
  parameter int DEPTH = 400,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/downsampler2.sv
// 2x2 box-average downsampler: raster pixels in, one rounded average per 2x2 block out.
module downsampler2
  import downsampler2_pkg::*;
#(
  parameter int NUMCOL = DEF_NUMCOL,
  parameter int NUMROW = DEF_NUMROW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic [7:0]       data,
  output logic [CNT_W-1:0] current_rowcount,
  output logic [CNT_W-1:0] current_colcount,
  output logic [7:0]       dataout,
  output logic             validout,
  output logic             frame_done
);

  localparam int HALF = NUMCOL / 2;
  localparam int AW   = $clog2(HALF);

  cnt_t       col_reg, col_next;
  cnt_t       row_reg, row_next;
  logic [7:0] hold_reg;
  logic [7:0] dataout_reg;
  logic       validout_reg;
  logic       frame_done_reg;

  logic          odd_col, odd_row, last_col, last_row;
  logic          lb_wr_en, lb_rd_en, out_beat;
  logic [AW-1:0] lb_addr;
  logic [8:0]    hsum;
  logic [8:0]    lb_rd_data;
  logic [9:0]    total;
  logic [7:0]    avg;

  always_comb begin
    odd_col  = col_reg[0];
    odd_row  = row_reg[0];
    last_col = (col_reg == cnt_t'(NUMCOL - 1));
    last_row = (row_reg == cnt_t'(NUMROW - 1));

    col_next = col_reg;
    row_next = row_reg;
    if (valid) begin
      col_next = wrap_inc(col_reg, NUMCOL - 1);
      if (last_col) begin
        row_next = wrap_inc(row_reg, NUMROW - 1);
      end
    end

    lb_addr  = col_reg[AW:1];
    lb_wr_en = valid & ~odd_row & odd_col;
    lb_rd_en = valid & odd_row & ~odd_col;
    out_beat = valid & odd_row & odd_col;

    hsum  = {1'b0, hold_reg} + {1'b0, data};
    // +2 before the divide-by-4 gives round-half-up; the 10-bit sum cannot exceed 1022.
    total = {1'b0, lb_rd_data} + {1'b0, hsum} + 10'd2;
    avg   = 8'(total >> 2);
  end

  line_buffer #(
    .DEPTH (HALF),
    .WIDTH (9),
    .AW    (AW)
  ) u_line_buffer (
    .clock   (clock),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (hsum),
    .rd_en   (lb_rd_en),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_reg        <= '0;
      row_reg        <= '0;
      hold_reg       <= '0;
      dataout_reg    <= '0;
      validout_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      col_reg        <= col_next;
      row_reg        <= row_next;
      validout_reg   <= out_beat;
      frame_done_reg <= out_beat & last_row & last_col;
      if (valid && !odd_col) begin
        hold_reg <= data;
      end
      if (out_beat) begin
        dataout_reg <= avg;
      end
    end
  end

  assign current_rowcount = row_reg;
  assign current_colcount = col_reg;
  assign dataout          = dataout_reg;
  assign validout         = validout_reg;
  assign frame_done       = frame_done_reg;

endmodule

// File: tb/tb_downsampler2.sv
// Randomised scoreboard bench for downsampler2 on a reduced frame size.
module tb_downsampler2;

  localparam int NC = 16;
  localparam int NR = 8;

  logic       clock;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  logic [9:0] current_rowcount;
  logic [9:0] current_colcount;
  logic [7:0] dataout;
  logic       validout;
  logic       frame_done;

  downsampler2 #(.NUMCOL(NC), .NUMROW(NR)) dut (
    .clock            (clock),
    .reset            (reset),
    .valid            (valid),
    .data             (data),
    .current_rowcount (current_rowcount),
    .current_colcount (current_colcount),
    .dataout          (dataout),
    .validout         (validout),
    .frame_done       (frame_done)
  );

  typedef struct {
    int val;
    int fd;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   img [NR][NC];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   n_pushed    = 0;
  int   n_out       = 0;
  int   fd_seen     = 0;
  int   frames_exp  = 0;
  int   last_dout   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every output pulse must match the head of the queue.
  always @(negedge clock) begin
    if (!reset) begin
      chk("reset_validout", int'(validout), 0);
      chk("reset_dataout", int'(dataout), 0);
      last_dout = 0;
    end else if (validout) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dataout", int'(dataout), e.val);
        chk("frame_done", int'(frame_done), e.fd);
        chk("out_latency_cycle", cyc, e.cyc);
      end
      n_out++;
      if (frame_done) fd_seen++;
      last_dout = int'(dataout);
    end else begin
      chk("dataout_hold", int'(dataout), last_dout);
      chk("frame_done_idle", int'(frame_done), 0);
    end
  end

  // Drives one frame; stop_at >= 0 abandons it before that raster index.
  task automatic run_frame(input int mode, input int gap_mode, input int stop_at);
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        img[r][c] = (mode == 0) ? 100 : int'($urandom_range(0, 255));
      end
    end
    if (mode == 1) begin
      img[0][0] = 1;   img[0][1] = 2;   img[1][0] = 3;   img[1][1] = 4;
      img[0][2] = 255; img[0][3] = 255; img[1][2] = 255; img[1][3] = 255;
      img[0][4] = 0;   img[0][5] = 0;   img[1][4] = 0;   img[1][5] = 1;
      img[0][6] = 0;   img[0][7] = 0;   img[1][6] = 1;   img[1][7] = 1;
    end
    for (int idx = 0; idx < NC * NR; idx++) begin
      int r, c, gaps, nidx;
      if (idx == stop_at) return;
      r = idx / NC;
      c = idx % NC;
      gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) begin
        valid = 1'b0;
        data  = 8'($urandom_range(0, 255));
        @(posedge clock);
        #1;
        chk("gap_rowcount", int'(current_rowcount), r);
        chk("gap_colcount", int'(current_colcount), c);
      end
      valid = 1'b1;
      data  = 8'(img[r][c]);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        exp_t e;
        e.val = (img[r-1][c-1] + img[r-1][c] + img[r][c-1] + img[r][c] + 2) / 4;
        e.fd  = (r == NR - 1 && c == NC - 1) ? 1 : 0;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
        n_pushed++;
      end
      @(posedge clock);
      #1;
      valid = 1'b0;
      nidx = (idx + 1) % (NC * NR);
      chk("rowcount", int'(current_rowcount), nidx / NC);
      chk("colcount", int'(current_colcount), nidx % NC);
    end
    frames_exp++;
  endtask

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    data  = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rowcount", int'(current_rowcount), 0);
    chk("reset_colcount", int'(current_colcount), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    reset = 1'b1;

    run_frame(0, 0, -1);  // constant 100, continuous valid
    run_frame(1, 0, -1);  // directed corner blocks
    run_frame(0, 1, -1);  // constant 100, valid one cycle in three
    run_frame(2, 0, -1);  // back-to-back random frames
    run_frame(2, 0, -1);

    // Abandon a frame at row 5, col 10 with an asynchronous reset.
    run_frame(2, 2, 5 * NC + 10);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("midreset_rowcount", int'(current_rowcount), 0);
    chk("midreset_colcount", int'(current_colcount), 0);
    chk("midreset_validout", int'(validout), 0);
    chk("midreset_dataout", int'(dataout), 0);
    chk("midreset_frame_done", int'(frame_done), 0);
    chk("midreset_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    run_frame(2, 2, -1);  // fresh frame after reset, random gaps

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
    repeat (2) @(posedge clock);
    #1;
    chk("drain_pending", exp_q.size(), 0);
    chk("output_count", n_out, n_pushed);
    chk("frame_done_count", fd_seen, frames_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/downsampler2.md
DOWNSAMPLER2 -- requirements
Module: downsampler2

Interface
REQ-001 Parameter NUMCOL, default 800: input pixels per row (even).
REQ-002 Parameter NUMROW, default 600: input rows per frame (even).
REQ-003 clock  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 valid  input  1  input pixel strobe; one pixel accepted per cycle when high.
REQ-006 data  input  8  input pixel, raster order, unsigned.
REQ-007 current_rowcount  output  10  row index of the next accepted input pixel.
REQ-008 current_colcount  output  10  column index of the next accepted input pixel.
REQ-009 dataout  output  8  2x2 box-averaged output pixel.
REQ-010 validout  output  1  dataout qualifier, one-cycle pulse per output pixel.
REQ-011 frame_done  output  1  one-cycle pulse coincident with the last output pixel of a frame.

Function
REQ-012 Column counter SHALL increment only on valid; at NUMCOL-1 it wraps to 0 and the row counter increments.
REQ-013 Row counter SHALL wrap from NUMROW-1 to 0 on the valid beat that completes the frame.
REQ-014 Counters SHALL hold when valid is low; gaps of any length SHALL NOT change the results.
REQ-015 Even-column beat: pixel latched into a holding register (8 bit).
REQ-016 Odd-column beat: hsum = hold + data, 9-bit unsigned, no overflow.
REQ-017 Even-row, odd-column beat: hsum written to line buffer address colcount>>1 (0..NUMCOL/2-1).
REQ-018 Odd-row, even-column beat: line buffer read issued at address colcount>>1; read data held until the next read.
REQ-019 Odd-row, odd-column beat: total = linebuf + hsum + 2 (10 bit); dataout = total>>2 (round half up, max 255, no saturation logic needed).
REQ-020 dataout/validout SHALL be registered: validout high exactly one cycle after the accepting odd-row, odd-column beat, low otherwise.
REQ-021 dataout SHALL hold its last value while validout is low.
REQ-022 Outputs per frame SHALL be exactly (NUMCOL/2)*(NUMROW/2) = 120000 at defaults.
REQ-023 frame_done SHALL pulse with the validout generated by the beat at row NUMROW-1, column NUMCOL-1.
REQ-024 Back-to-back frames SHALL need no idle cycles; row 0 of the next frame overwrites the line buffer.

Reset
REQ-025 While reset is low: counters 0, hold register 0, dataout 0, validout 0, frame_done 0, immediately (asynchronous).
REQ-026 Reset mid-frame SHALL discard the partial frame; the first valid after release is pixel (0,0).
REQ-027 Line buffer contents SHALL NOT be cleared; they are always written before being read.

Structure
REQ-028 NUMCOL, NUMROW, and counter width (10) SHALL come from the shared sampling package also used by the upsampler.
REQ-029 The line buffer SHALL be a sub-module line_buffer: NUMCOL/2 x 9-bit simple dual-port RAM, synchronous read with read-enable.
REQ-030 Total RTL 120-400 lines; no FIFO inside; output connects directly to the upsampler-side FIFO write.

Verification
REQ-031 Constant pixel 100, continuous valid, one frame -> 120000 validout pulses, all dataout=100; first pulse one cycle after input beat 801 (row 1, col 1).
REQ-032 Block at (0,0),(0,1),(1,0),(1,1) = 1,2,3,4 -> first dataout=3; all-255 block -> 255; block 0,0,0,1 -> 0; block 0,0,1,1 -> 1.
REQ-033 Same frame with valid high one cycle in three -> identical dataout sequence to REQ-031 case; counters advance only on valid.
REQ-034 Two frames back-to-back -> frame_done pulses exactly twice, each with the 120000th output of its frame; counters read 0,0 after each.
REQ-035 Reset low at row 5, col 300 -> validout/dataout/counters 0 in the same cycle; fresh frame after release yields a correct 120000-pixel output.
